// File: rtl/nand_bus_sequencer.sv
// nand_bus_sequencer: runs one NAND bus primitive (CMD/ADDR/WRITE/READ/WAIT_RB) per handshake.
// Ports: op_valid/op_ready/op_type/op_data carry the request from the controller.
//        ce_hold keeps nCE low between ops. wp_n drives nWP.
//        rd_valid/rd_data return read data. rb_busy is the synchronised inverse of RnB.
//        nand_* are the conduit pins. nand_data_oe enables the top-level tristate.
// Optional: define NAND_RB_TIMEOUT_EN to add rb_timeout, which aborts WAIT_RB after RB_TIMEOUT cycles.
module nand_bus_sequencer #(
   parameter int T_WP       = 2,
   parameter int T_WH       = 2,
   parameter int T_RP       = 2,
   parameter int T_REH      = 2,
   parameter int T_WB       = 5,
   parameter int RB_TIMEOUT = 1048576
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [2:0]  op_type,
   input  logic [15:0] op_data,
   input  logic        ce_hold,
   input  logic        wp_n,
   output logic        rd_valid,
   output logic [15:0] rd_data,
   output logic        rb_busy,
`ifdef NAND_RB_TIMEOUT_EN
   output logic        rb_timeout,
`endif
   output logic        nand_ale,
   output logic        nand_cle,
   output logic        nand_nce,
   output logic        nand_nre,
   output logic        nand_nwe,
   output logic        nand_nwp,
   output logic [15:0] nand_data_o,
   output logic        nand_data_oe,
   input  logic [15:0] nand_data_i,
   input  logic        nand_rnb
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WE_LO   = 3'd1;
   localparam logic [2:0] S_WE_HI   = 3'd2;
   localparam logic [2:0] S_RE_LO   = 3'd3;
   localparam logic [2:0] S_RE_HI   = 3'd4;
   localparam logic [2:0] S_WB_WAIT = 3'd5;
   localparam logic [2:0] S_RB_WAIT = 3'd6;
   localparam int M1   = (T_WP > T_WH) ? T_WP : T_WH;
   localparam int M2   = (T_RP > T_REH) ? T_RP : T_REH;
   localparam int M3   = (M1 > M2) ? M1 : M2;
   localparam int MAXP = (M3 > T_WB) ? M3 : T_WB;
   localparam int CW   = $clog2(MAXP) + 1;
   // Phase counter is loaded with length-1 and the phase ends when it reads zero.
   localparam logic [CW-1:0] L_WP  = CW'(T_WP - 1);
   localparam logic [CW-1:0] L_WH  = CW'(T_WH - 1);
   localparam logic [CW-1:0] L_RP  = CW'(T_RP - 1);
   localparam logic [CW-1:0] L_REH = CW'(T_REH - 1);
   localparam logic [CW-1:0] L_WB  = CW'(T_WB - 1);
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          op_ready_q, op_ready_d;
   logic          cle_q, cle_d, ale_q, ale_d;
   logic          nce_q, nce_d, nre_q, nre_d, nwe_q, nwe_d, nwp_q, nwp_d;
   logic [15:0]   data_o_q, data_o_d;
   logic          oe_q, oe_d;
   logic          rd_valid_q, rd_valid_d;
   logic [15:0]   rd_data_q, rd_data_d;
   logic [1:0]    sync_q, sync_d;
`ifdef NAND_RB_TIMEOUT_EN
   localparam logic [20:0] TO_LAST = 21'(RB_TIMEOUT - 1);
   logic [20:0]   to_q, to_d;
   logic          rb_to_q, rb_to_d;
`else
   logic          unused_to;
   assign unused_to = ^RB_TIMEOUT;
`endif
   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      cle_d      = cle_q;
      ale_d      = ale_q;
      nre_d      = nre_q;
      nwe_d      = nwe_q;
      data_o_d   = data_o_q;
      oe_d       = oe_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      sync_d     = {sync_q[0], nand_rnb};
`ifdef NAND_RB_TIMEOUT_EN
      to_d       = to_q;
      rb_to_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (op_valid && op_ready_q) begin
               if (op_type <= 3'd2) begin
                  state_d  = S_WE_LO;
                  cnt_d    = L_WP;
                  nwe_d    = 1'b0;
                  cle_d    = (op_type == 3'd0);
                  ale_d    = (op_type == 3'd1);
                  oe_d     = 1'b1;
                  data_o_d = op_data;
               end else if (op_type == 3'd3) begin
                  state_d = S_RE_LO;
                  cnt_d   = L_RP;
                  nre_d   = 1'b0;
               end else if (op_type == 3'd4) begin
                  state_d = S_WB_WAIT;
                  cnt_d   = L_WB;
               end
            end
         end
         S_WE_LO: begin
            if (cnt_q == '0) begin
               state_d = S_WE_HI;
               cnt_d   = L_WH;
               nwe_d   = 1'b1;
            end
         end
         S_WE_HI: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               cle_d   = 1'b0;
               ale_d   = 1'b0;
               oe_d    = 1'b0;
            end
         end
         S_RE_LO: begin
            // Sample the bus on the edge that raises nRE.
            if (cnt_q == '0) begin
               state_d    = S_RE_HI;
               cnt_d      = L_REH;
               nre_d      = 1'b1;
               rd_data_d  = nand_data_i;
               rd_valid_d = 1'b1;
            end
         end
         S_RE_HI: state_d = (cnt_q == '0) ? S_IDLE : S_RE_HI;
         S_WB_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RB_WAIT;
`ifdef NAND_RB_TIMEOUT_EN
               to_d    = '0;
`endif
            end
         end
         S_RB_WAIT: begin
`ifdef NAND_RB_TIMEOUT_EN
            to_d = to_q + 21'd1;
            if (sync_q[1]) state_d = S_IDLE;
            else if (to_q == TO_LAST) begin
               state_d = S_IDLE;
               rb_to_d = 1'b1;
            end
`else
            if (sync_q[1]) state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
      // Both follow the next state so nCE falls together with the first strobe.
      nce_d      = !((state_d != S_IDLE) || ce_hold);
      op_ready_d = (state_d == S_IDLE);
      nwp_d      = wp_n;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_ready_q <= 1'b0;
         cle_q      <= 1'b0;
         ale_q      <= 1'b0;
         nce_q      <= 1'b1;
         nre_q      <= 1'b1;
         nwe_q      <= 1'b1;
         nwp_q      <= 1'b0;
         data_o_q   <= '0;
         oe_q       <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         sync_q     <= 2'b11;
`ifdef NAND_RB_TIMEOUT_EN
         to_q       <= '0;
         rb_to_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_ready_q <= op_ready_d;
         cle_q      <= cle_d;
         ale_q      <= ale_d;
         nce_q      <= nce_d;
         nre_q      <= nre_d;
         nwe_q      <= nwe_d;
         nwp_q      <= nwp_d;
         data_o_q   <= data_o_d;
         oe_q       <= oe_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         sync_q     <= sync_d;
`ifdef NAND_RB_TIMEOUT_EN
         to_q       <= to_d;
         rb_to_q    <= rb_to_d;
`endif
      end
   end
   assign op_ready     = op_ready_q;
   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;
   assign rb_busy      = ~sync_q[1];
   assign nand_ale     = ale_q;
   assign nand_cle     = cle_q;
   assign nand_nce     = nce_q;
   assign nand_nre     = nre_q;
   assign nand_nwe     = nwe_q;
   assign nand_nwp     = nwp_q;
   assign nand_data_o  = data_o_q;
   assign nand_data_oe = oe_q;
`ifdef NAND_RB_TIMEOUT_EN
   assign rb_timeout   = rb_to_q;
`endif
endmodule
